wsat_table_test: RTL and testbench
==================================

Name: wsat_table_test

Overview:
- Lookup/fetch block of the WSAT (WalkSAT) accelerator.
- Takes candidate variable indices from an unsatisfied-clause buffer and looks each one up in an address table (clause-list base pointer plus 20-bit occurrence mask).
- Fetches up to 20 clause words from the clause table and presents them on 20 parallel 36-bit lanes, one lane per downstream clause evaluator.
- All tables are internal memories, preloaded by backdoor.

Parameters:
- NVAR, 2048, variable-table depth; index 0 is reserved as the null variable.
- NLANE, 20, clause lanes per lookup.
- CT_DEPTH, 4096, clause-table depth (12-bit address).
- CW, 36, clause word width: 3 literals x 12 bits, each literal = {sign, 11-bit var}.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- reg_en  in  1  pipeline advance enable; low = all registers hold.
- boot  in  1  load variable snapshot and flush pipeline.
- temp_out  out  [NLANE:1][35:0]  fetched clause words; lane k indexed 1..20.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset: temp_out all lanes = 0, ucb pointer = 0, pipeline valids = 0, internal read = 0.
- Internal storage. These hierarchical names are fixed because benches preload them:
  - AT.address_mem[0:2047]: 12-bit CT base address.
  - AT.Mask_mem[0:2047]: 20-bit lane mask.
  - CT.mem[0:4095]: 36-bit clause words.
  - ucb.mem[0:2047]: 11-bit variable index.
  - value_mem[0:2047]: 1-bit truth values.
  - var_table_in[0:2047]: 1-bit working assignment.
  - read: 1-bit internal start flag, written by bench hierarchy and reset to 0.
- Boot: when boot=1 (rising edge), var_table_in[i] <= value_mem[i] for all i, all pipeline valids clear, and temp_out clears to 0. Boot has priority over read and reg_en.
- Pipeline:
  - Advances only when reg_en=1 and boot=0.
  - S0, while read=1: v <= ucb.mem[ptr]; ptr <= ptr+1, wrapping 2047->0.
  - S1: base <= AT.address_mem[v]; mask <= AT.Mask_mem[v].
  - S2: for k=1..20, temp_out[k] <= mask[k-1] ? CT.mem[(base+k-1) mod 4096] : 36'h0.
- Latency and throughput: first valid temp_out appears 3 enabled edges after read is sampled high. Throughput is one lookup per cycle.
- v=0 (null variable): the S1/S2 lookup proceeds normally. AT.address_mem[0] contents are don't-care; AT.Mask_mem[0] must be 0, which yields all-zero lanes.
- Hold conditions: when reg_en=0, outputs, pointer and stage registers hold. When read drops, S0 stops issuing, in-flight lookups drain, and temp_out then holds its last value.
- Evaluators: lane k feeds evaluator[k].ce, a combinational clause check against var_table_in:
  - sat[k] = OR over the 3 literals of (var!=0 && (var_table_in[var] ^ sign)).
  - Literal with var 0 = absent.
  - sat is internal only; no port.

Decomposition:
- Package wsat_pkg: NVAR, NLANE, CT_DEPTH, CW, literal typedef {logic sign; logic [10:0] var}, clause typedef (3 literals).
- Sub-module clause_eval: one clause word plus variable table in, sat out. Instantiated 20x in a generate named evaluator[k].ce.
- The AT, CT and ucb memories are plain arrays inside the instances named AT, CT and ucb.

Test Plan:
- Reset: rst=1 for 1 cycle -> all temp_out = 0, ptr = 0.
- Boot: value_mem[3]=1, boot=1 for 1 cycle -> var_table_in[3]=1 on the next edge; temp_out stays 0.
- Single lookup: ucb.mem[0]=5, address_mem[5]=12'h020, Mask_mem[5]=20'h00003, CT.mem[0x20]=36'h000800801, CT.mem[0x21]=36'h123456789; reg_en=1, read=1 for one cycle -> on the 3rd edge temp_out[1]=36'h000800801, temp_out[2]=36'h123456789, lanes 3..20 = 0.
- Mask and wrap: address_mem[v]=12'hFFF with full mask 20'hFFFFF -> lane 1 = CT[0xFFF], lane 2 = CT[0x000], lane 20 = CT[0x012].
- Stall: deassert reg_en mid-stream for 3 cycles -> temp_out and ptr frozen; resume continues with no skipped or duplicated ucb entries.
- Evaluator: var_table_in[1]=0; clause with literals {sign=1, var=1},{0,0},{0,0} -> sat=1. Flip var_table_in[1] to 1 -> sat=0.

Source files
------------

// File: rtl/wsat_table_test_pkg.sv
// Shared sizes and clause/literal layout for the WSAT lookup/fetch slice.
package wsat_pkg;
    localparam int NVAR     = 2048;
    localparam int NLANE    = 20;
    localparam int CT_DEPTH = 4096;
    localparam int CW       = 36;
    localparam int VW       = 11;
    localparam int AW       = 12;

    typedef struct packed {
        logic          sign;
        logic [VW-1:0] var_idx;
    } literal_t;

    typedef struct packed {
        literal_t lit2;
        literal_t lit1;
        literal_t lit0;
    } clause_t;
endpackage

// File: rtl/wsat_table_test_clause_eval.sv
// Combinational clause check: true when any present literal is satisfied.
module clause_eval
    import wsat_pkg::*;
(
    input  logic [CW-1:0] clause_word,
    input  logic          var_table [0:NVAR-1],
    output logic          sat
);
    clause_t    c;
    logic [2:0] hit;

    assign c = clause_word;

    // var_idx 0 marks an absent literal
    assign hit[0] = (c.lit0.var_idx != '0) && (var_table[c.lit0.var_idx] ^ c.lit0.sign);
    assign hit[1] = (c.lit1.var_idx != '0) && (var_table[c.lit1.var_idx] ^ c.lit1.sign);
    assign hit[2] = (c.lit2.var_idx != '0) && (var_table[c.lit2.var_idx] ^ c.lit2.sign);

    assign sat = |hit;
endmodule

// File: rtl/wsat_table_test_mem.sv
// Table storage: unsatisfied-clause buffer, address table and clause table.
// Write ports exist only so the arrays have a driver; normal loading is by backdoor.
module ucb_mem
    import wsat_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [VW-1:0] waddr,
    input  logic [VW-1:0] wdata,
    input  logic [VW-1:0] raddr,
    output logic [VW-1:0] rdata
);
    logic [VW-1:0] mem [0:NVAR-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module at_mem
    import wsat_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [VW-1:0]    waddr,
    input  logic [AW-1:0]    wbase,
    input  logic [NLANE-1:0] wmask,
    input  logic [VW-1:0]    raddr,
    output logic [AW-1:0]    rbase,
    output logic [NLANE-1:0] rmask
);
    logic [AW-1:0]    address_mem [0:NVAR-1];
    logic [NLANE-1:0] Mask_mem    [0:NVAR-1];

    always_ff @(posedge clk) begin
        if (we) begin
            address_mem[waddr] <= wbase;
            Mask_mem[waddr]    <= wmask;
        end
    end

    assign rbase = address_mem[raddr];
    assign rmask = Mask_mem[raddr];
endmodule

module ct_mem
    import wsat_pkg::*;
(
    input  logic                      clk,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [CW-1:0]             wdata,
    input  logic [NLANE-1:0][AW-1:0]  raddr,
    output logic [NLANE-1:0][CW-1:0]  rdata
);
    logic [CW-1:0] mem [0:CT_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    for (genvar gi = 0; gi < NLANE; gi++) begin : g_rd
        assign rdata[gi] = mem[raddr[gi]];
    end
endmodule

// File: rtl/wsat_table_test.sv
// Three-stage lookup: ucb index -> address/mask -> 20 masked clause words,
// each lane checked by its own clause evaluator against the working assignment.
module wsat_table_test
    import wsat_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_en,
    input  logic                     boot,
    output logic [NLANE:1][CW-1:0]   temp_out
);
    logic                     read;
    logic [VW-1:0]            ptr_q, ptr_d;
    logic [VW-1:0]            v_q, v_d;
    logic                     s0_valid_q, s0_valid_d;
    logic [AW-1:0]            base_q, base_d;
    logic [NLANE-1:0]         mask_q, mask_d;
    logic                     s1_valid_q, s1_valid_d;
    logic [NLANE:1][CW-1:0]   temp_out_q, temp_out_d;

    logic                     value_mem    [0:NVAR-1];
    logic                     var_table_in [0:NVAR-1];
    logic [NLANE:1]           sat;

    logic [VW-1:0]            ucb_rdata;
    logic [AW-1:0]            at_base;
    logic [NLANE-1:0]         at_mask;
    logic [NLANE-1:0][AW-1:0] ct_raddr;
    logic [NLANE-1:0][CW-1:0] ct_rdata;

    logic                     tie_we;
    logic [AW-1:0]            tie_addr;
    logic [CW-1:0]            tie_data;

    assign tie_we   = 1'b0;
    assign tie_addr = '0;
    assign tie_data = '0;

    ucb_mem ucb (
        .clk(clk), .we(tie_we), .waddr(tie_addr[VW-1:0]), .wdata(tie_data[VW-1:0]),
        .raddr(ptr_q), .rdata(ucb_rdata)
    );

    at_mem AT (
        .clk(clk), .we(tie_we), .waddr(tie_addr[VW-1:0]), .wbase(tie_data[AW-1:0]),
        .wmask(tie_data[NLANE-1:0]), .raddr(v_q), .rbase(at_base), .rmask(at_mask)
    );

    // Consecutive clause addresses wrap modulo the 12-bit table size
    for (genvar gi = 0; gi < NLANE; gi++) begin : g_addr
        assign ct_raddr[gi] = base_q + AW'(gi);
    end

    ct_mem CT (
        .clk(clk), .we(tie_we), .waddr(tie_addr), .wdata(tie_data),
        .raddr(ct_raddr), .rdata(ct_rdata)
    );

    always_ff @(posedge clk) begin
        if (tie_we) value_mem[tie_addr[VW-1:0]] <= tie_data[0];
    end

    always_ff @(posedge clk) begin
        if (boot) var_table_in <= value_mem;
    end

    always_comb begin
        ptr_d      = ptr_q;
        v_d        = v_q;
        s0_valid_d = s0_valid_q;
        base_d     = base_q;
        mask_d     = mask_q;
        s1_valid_d = s1_valid_q;
        temp_out_d = temp_out_q;
        if (boot) begin
            s0_valid_d = 1'b0;
            s1_valid_d = 1'b0;
            temp_out_d = '0;
        end else if (reg_en) begin
            s0_valid_d = read;
            if (read) begin
                v_d   = ucb_rdata;
                ptr_d = ptr_q + 1'b1;
            end
            base_d     = at_base;
            mask_d     = at_mask;
            s1_valid_d = s0_valid_q;
            // Output holds once the pipeline drains
            if (s1_valid_q) begin
                for (int k = 1; k <= NLANE; k++) begin
                    temp_out_d[k] = mask_q[k-1] ? ct_rdata[k-1] : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            v_q        <= '0;
            s0_valid_q <= 1'b0;
            base_q     <= '0;
            mask_q     <= '0;
            s1_valid_q <= 1'b0;
            temp_out_q <= '0;
            read       <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            v_q        <= v_d;
            s0_valid_q <= s0_valid_d;
            base_q     <= base_d;
            mask_q     <= mask_d;
            s1_valid_q <= s1_valid_d;
            temp_out_q <= temp_out_d;
            read       <= read;
        end
    end

    assign temp_out = temp_out_q;

    for (genvar gi = 1; gi <= NLANE; gi++) begin : evaluator
        clause_eval ce (
            .clause_word(temp_out_q[gi]),
            .var_table  (var_table_in),
            .sat        (sat[gi])
        );
    end
endmodule

// File: tb/tb_wsat_table_test.sv
// Randomized scoreboard bench for wsat_table_test against a table-level reference model.
module tb_wsat_table_test;
    typedef logic [20:1][35:0] lanes_t;
    typedef struct {
        lanes_t      lanes;
        int          due;
        logic [10:0] v;
    } exp_t;

    logic   clk;
    logic   rst;
    logic   reg_en;
    logic   boot;
    lanes_t temp_out;

    wsat_table_test dut (
        .clk(clk), .rst(rst), .reg_en(reg_en), .boot(boot), .temp_out(temp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] m_ucb   [2048];
    logic [11:0] m_addr  [2048];
    logic [19:0] m_mask  [2048];
    logic [35:0] m_ct    [4096];
    logic        m_value [2048];
    logic        m_vt    [2048];

    exp_t        sb_q[$];
    lanes_t      last_exp;
    logic [10:0] m_ptr;
    int          en_edges;
    int          txn;
    bit          booted;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [719:0] act, input logic [719:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic lanes_t lookup(input logic [10:0] v);
        lanes_t r;
        for (int k = 1; k <= 20; k++) begin
            r[k] = m_mask[v][k-1] ? m_ct[(int'(m_addr[v]) + k - 1) % 4096] : 36'h0;
        end
        return r;
    endfunction

    function automatic logic [20:1] model_sat(input lanes_t w);
        logic [20:1] s;
        for (int k = 1; k <= 20; k++) begin
            s[k] = 1'b0;
            for (int j = 0; j < 3; j++) begin
                logic [11:0] lit;
                lit = w[k][j*12 +: 12];
                if (lit[10:0] != 11'd0 && (m_vt[lit[10:0]] ^ lit[11])) s[k] = 1'b1;
            end
        end
        return s;
    endfunction

    // Monitor: follows each enabled edge, pops due responses and compares
    always @(posedge clk) begin
        bit s_rst, s_boot, s_en, s_read;
        s_rst  = rst;
        s_boot = boot;
        s_en   = reg_en;
        s_read = dut.read;
        if (s_rst) begin
            sb_q.delete();
            last_exp = '0;
            m_ptr    = '0;
        end else if (s_boot) begin
            sb_q.delete();
            last_exp = '0;
            for (int i = 0; i < 2048; i++) m_vt[i] = m_value[i];
            booted = 1'b1;
        end else if (s_en) begin
            en_edges++;
            if (s_read) begin
                exp_t e;
                e.v     = m_ucb[m_ptr];
                e.lanes = lookup(e.v);
                e.due   = en_edges + 2;
                sb_q.push_back(e);
                m_ptr = m_ptr + 11'd1;
            end
        end
        #1;
        if (sb_q.size() > 0 && sb_q[0].due == en_edges) begin
            exp_t e;
            e = sb_q.pop_front();
            last_exp = e.lanes;
            txn++;
            $display("txn %0d var %0d lane1 %h lane20 %h", txn, e.v, e.lanes[1], e.lanes[20]);
        end
        chk("temp_out", 720'(temp_out), 720'(last_exp));
        chk("ptr", 720'(dut.ptr_q), 720'(m_ptr));
        if (s_boot) begin
            chk("var_table_in[1]", 720'(dut.var_table_in[1]), 720'(m_vt[1]));
            chk("var_table_in[3]", 720'(dut.var_table_in[3]), 720'(m_vt[3]));
        end
        if (booted) chk("sat", 720'(dut.sat), 720'(model_sat(last_exp)));
    end

    initial begin
        checks   = 0;
        errors   = 0;
        en_edges = 0;
        txn      = 0;
        booted   = 1'b0;
        last_exp = '0;
        m_ptr    = '0;
        rst      = 1'b1;
        boot     = 1'b0;
        reg_en   = 1'b0;
        dut.read = 1'b0;

        for (int i = 0; i < 2048; i++) begin
            m_ucb[i]   = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
            m_addr[i]  = 12'($urandom);
            m_mask[i]  = 20'($urandom);
            m_value[i] = 1'($urandom);
        end
        for (int i = 0; i < 4096; i++) m_ct[i] = {4'($urandom), 32'($urandom)};
        m_mask[0]     = 20'h0;
        m_ucb[0]      = 11'd5;
        m_ucb[1]      = 11'd7;
        m_addr[5]     = 12'h020;
        m_mask[5]     = 20'h00003;
        m_ct[12'h020] = 36'h000800801;
        m_ct[12'h021] = 36'h123456789;
        m_addr[7]     = 12'hFFF;
        m_mask[7]     = 20'hFFFFF;
        m_value[1]    = 1'b0;
        m_value[3]    = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            dut.ucb.mem[i]        = m_ucb[i];
            dut.AT.address_mem[i] = m_addr[i];
            dut.AT.Mask_mem[i]    = m_mask[i];
            dut.value_mem[i]      = m_value[i];
        end
        for (int i = 0; i < 4096; i++) dut.CT.mem[i] = m_ct[i];

        @(negedge clk);
        rst  = 1'b0;
        boot = 1'b1;
        @(negedge clk);
        boot     = 1'b0;
        reg_en   = 1'b1;
        dut.read = 1'b1;
        @(negedge clk);
        dut.read = 1'b0;
        repeat (4) @(negedge clk);
        dut.read = 1'b1;
        @(negedge clk);
        dut.read = 1'b0;
        repeat (4) @(negedge clk);

        // Stall in the middle of a stream
        dut.read = 1'b1;
        repeat (3) @(negedge clk);
        reg_en = 1'b0;
        repeat (3) @(negedge clk);
        reg_en = 1'b1;
        repeat (3) @(negedge clk);

        for (int c = 0; c < 4000; c++) begin
            reg_en   = ($urandom_range(0, 3) != 0);
            dut.read = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) begin
                for (int i = 0; i < 2048; i++) begin
                    m_value[i]       = 1'($urandom);
                    dut.value_mem[i] = m_value[i];
                end
                boot = 1'b1;
            end else begin
                boot = 1'b0;
            end
            @(negedge clk);
        end

        boot     = 1'b0;
        reg_en   = 1'b1;
        dut.read = 1'b0;
        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 720'(sb_q.size()), 720'(0));
        chk("final_ptr", 720'(dut.ptr_q), 720'(m_ptr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
